// File: rtl/contrast_pkg.sv
// Shared definitions for the contrast destretch block: default pixel range,
// FSM state encoding (4-bit, same layout as the stretch block) and the flat-frame flag.
// Optional build macro used by the top: CONTRAST_DESTRETCH_ROUND_EN.
package contrast_pkg;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefMin       = 0;
   localparam int unsigned DefMax       = 255;
   localparam int unsigned DefValue     = DefMax - DefMin;

   typedef enum logic [3:0] {
      StIdle  = 4'd0,
      StArmed = 4'd1,
      StMult  = 4'd2,
      StDiv   = 4'd3,
      StOut   = 4'd4,
      StDone  = 4'd5
   } state_e;

   // Value of the latched flag when max <= min: output is min, no arithmetic.
   localparam logic FlatFrame = 1'b1;

endpackage

// File: rtl/seq_restoring_div.sv
// Fixed-latency sequential restoring divider. While en_i is high it retires one
// quotient bit per cycle, MSB first; done_o marks the last step, during which
// quotient_o already carries the final result. Dropping en_i rearms it.
module seq_restoring_div #(
   parameter int unsigned DvdWidth  = 16,
   parameter int unsigned DivWidth  = 8,
   parameter int unsigned QuotWidth = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic [DvdWidth-1:0]  dividend_i,
   input  logic [DivWidth-1:0]  divisor_i,
   output logic [QuotWidth-1:0] quotient_o,
   output logic                 done_o
);

   localparam int unsigned CntW = $clog2(DvdWidth);

   logic [CntW-1:0]      cnt_q;
   logic [DivWidth-1:0]  rem_q, rem_d, rem_src;
   logic [DvdWidth-1:0]  dvd_q, dvd_d, dvd_src;
   logic [QuotWidth-1:0] quot_q, quot_d;
   logic [DivWidth:0]    rem_try;
   logic                 qbit, last;

   // One restoring step; the first step takes the dividend straight from the port.
   always_comb begin
      last    = (cnt_q == CntW'(DvdWidth - 1));
      dvd_src = (cnt_q == '0) ? dividend_i : dvd_q;
      rem_src = (cnt_q == '0) ? '0 : rem_q;
      rem_try = {rem_src, dvd_src[DvdWidth-1]};
      qbit    = 1'b0;
      rem_d   = rem_try[DivWidth-1:0];
      if (rem_try >= {1'b0, divisor_i}) begin
         qbit  = 1'b1;
         rem_d = DivWidth'(rem_try - {1'b0, divisor_i});
      end
      dvd_d      = dvd_src << 1;
      // Stale bits shift out: DvdWidth >= QuotWidth steps always run.
      quot_d     = (quot_q << 1) | QuotWidth'(qbit);
      quotient_o = quot_d;
      done_o     = en_i & last;
   end

   // Step state; the counter parks at zero whenever the divider is not enabled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         rem_q  <= '0;
         dvd_q  <= '0;
         quot_q <= '0;
      end else if (!en_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q  <= last ? '0 : cnt_q + 1'b1;
         rem_q  <= rem_d;
         dvd_q  <= dvd_d;
         quot_q <= quot_d;
      end
   end

endmodule

// File: rtl/contrast_destretch.sv
// Maps stretched pixels in [MIN, MAX] back to the frame's original [min, max]:
// out = min + (clamp(px) - MIN) * (max - min) / VALUE, one pixel in flight.
// Build option CONTRAST_DESTRETCH_ROUND_EN: round-to-nearest, one extra divide cycle.
module contrast_destretch
   import contrast_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned RAM_DEPTH  = 76800,
   parameter int unsigned ADDR_WIDTH = $clog2(RAM_DEPTH),
   parameter int unsigned MAX        = DefMax,
   parameter int unsigned MIN        = DefMin,
   parameter int unsigned VALUE      = MAX - MIN
) (
   input  logic                  clk_i_destretch,
   input  logic                  rstn_i_destretch,
   input  logic                  start_i_destretch,
   input  logic [DATA_WIDTH-1:0] min_i_destretch,
   input  logic [DATA_WIDTH-1:0] max_i_destretch,
   input  logic                  valid_i_destretch,
   input  logic [DATA_WIDTH-1:0] data_i_destretch,
   output logic                  ready_o_destretch,
   output logic                  valid_o_destretch,
   output logic [DATA_WIDTH-1:0] data_o_destretch,
   input  logic                  ready_i_destretch,
   output logic                  busy_o_destretch,
   output logic                  done_o_destretch
);

   localparam int unsigned W       = DATA_WIDTH;
   localparam int unsigned ProdW   = 2 * W;
   localparam int unsigned MulCntW = $clog2(W + 1);
`ifdef CONTRAST_DESTRETCH_ROUND_EN
   localparam int unsigned DvdW    = 2 * W + 1;
`else
   localparam int unsigned DvdW    = 2 * W;
`endif

   state_e                state_q;
   logic [W-1:0]          min_q, max_q, data_q, mplier_q;
   logic                  flat_q, ready_q, valid_q, busy_q, done_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic [MulCntW-1:0]    mcnt_q;
   logic [ProdW-1:0]      mcand_q, prod_q;

   logic [31:0]   px_ext, px_clamp;
   logic [W-1:0]  px_off, span, quot, out_sat;
   logic [W:0]    out_sum;
   logic [DvdW-1:0] dividend;
   logic          div_en, div_done;

   // Input clamp/offset, divider operand and saturated output value.
   always_comb begin
      px_ext   = 32'(data_i_destretch);
      px_clamp = px_ext;
      if (px_ext < MIN) begin
         px_clamp = MIN;
      end else if (px_ext > MAX) begin
         px_clamp = MAX;
      end
      px_off = W'(px_clamp - MIN);
      span   = max_q - min_q;
`ifdef CONTRAST_DESTRETCH_ROUND_EN
      dividend = {1'b0, prod_q} + DvdW'(VALUE / 2);
`else
      dividend = prod_q;
`endif
      out_sum = {1'b0, min_q} + {1'b0, quot};
      out_sat = (out_sum > {1'b0, max_q}) ? max_q : out_sum[W-1:0];
      div_en  = (state_q == StDiv);
   end

   seq_restoring_div #(
      .DvdWidth  (DvdW),
      .DivWidth  (W),
      .QuotWidth (W)
   ) u_div (
      .clk_i      (clk_i_destretch),
      .rst_ni     (rstn_i_destretch),
      .en_i       (div_en),
      .dividend_i (dividend),
      .divisor_i  (W'(VALUE)),
      .quotient_o (quot),
      .done_o     (div_done)
   );

   // Frame FSM with registered handshake/status outputs and the inline shift-add multiply.
   always_ff @(posedge clk_i_destretch or negedge rstn_i_destretch) begin
      if (!rstn_i_destretch) begin
         state_q  <= StIdle;
         min_q    <= '0;
         max_q    <= '0;
         flat_q   <= 1'b0;
         cnt_q    <= '0;
         mcnt_q   <= '0;
         mplier_q <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         data_q   <= '0;
         ready_q  <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i_destretch) begin
                  min_q   <= min_i_destretch;
                  max_q   <= max_i_destretch;
                  flat_q  <= (max_i_destretch <= min_i_destretch);
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= StArmed;
               end
            end
            StArmed: begin
               if (valid_i_destretch) begin
                  ready_q <= 1'b0;
                  if (flat_q == FlatFrame) begin
                     data_q  <= min_q;
                     valid_q <= 1'b1;
                     state_q <= StOut;
                  end else begin
                     mplier_q <= px_off;
                     mcand_q  <= {{W{1'b0}}, span};
                     prod_q   <= '0;
                     mcnt_q   <= '0;
                     state_q  <= StMult;
                  end
               end
            end
            StMult: begin
               if (mplier_q[0]) begin
                  prod_q <= prod_q + mcand_q;
               end
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               mcnt_q   <= mcnt_q + 1'b1;
               if (mcnt_q == MulCntW'(W - 1)) begin
                  state_q <= StDiv;
               end
            end
            StDiv: begin
               if (div_done) begin
                  data_q  <= out_sat;
                  valid_q <= 1'b1;
                  state_q <= StOut;
               end
            end
            StOut: begin
               if (ready_i_destretch) begin
                  valid_q <= 1'b0;
                  if (cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     cnt_q   <= cnt_q + 1'b1;
                     ready_q <= 1'b1;
                     state_q <= StArmed;
                  end
               end
            end
            StDone: begin
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ready_o_destretch = ready_q;
   assign valid_o_destretch = valid_q;
   assign data_o_destretch  = data_q;
   assign busy_o_destretch  = busy_q;
   assign done_o_destretch  = done_q;

endmodule

// File: tb/tb_contrast_destretch.sv
// Randomised self-checking bench for contrast_destretch with a 4-pixel frame.
// Honours CONTRAST_DESTRETCH_ROUND_EN for expected values and latency.
module tb_contrast_destretch;

   localparam int unsigned W     = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MINV  = 0;
   localparam int unsigned MAXV  = 255;
   localparam int unsigned VAL   = MAXV - MINV;
`ifdef CONTRAST_DESTRETCH_ROUND_EN
   localparam int LAT = 3 * W + 2;
`else
   localparam int LAT = 3 * W + 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       valid_i = 1'b0;
   logic       ready_i = 1'b1;
   logic [7:0] min_i = '0;
   logic [7:0] max_i = '0;
   logic [7:0] data_i = '0;
   logic       ready_o, valid_o, busy_o, done_o;
   logic [7:0] data_o;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) if (done_o === 1'b1) done_cnt++;

   contrast_destretch #(
      .DATA_WIDTH (W),
      .RAM_DEPTH  (DEPTH),
      .MAX        (MAXV),
      .MIN        (MINV)
   ) dut (
      .clk_i_destretch   (clk),
      .rstn_i_destretch  (rst_n),
      .start_i_destretch (start),
      .min_i_destretch   (min_i),
      .max_i_destretch   (max_i),
      .valid_i_destretch (valid_i),
      .data_i_destretch  (data_i),
      .ready_o_destretch (ready_o),
      .valid_o_destretch (valid_o),
      .data_o_destretch  (data_o),
      .ready_i_destretch (ready_i),
      .busy_o_destretch  (busy_o),
      .done_o_destretch  (done_o)
   );

   // Reference: linear remap of the clamped pixel from [MIN,MAX] onto [mn,mx].
   function automatic logic [7:0] ref_out(input int px, input int mn, input int mx);
      int c, q, r;
      if (mx <= mn) return 8'(mn);
      c = px;
      if (c < int'(MINV)) c = MINV;
      if (c > int'(MAXV)) c = MAXV;
      c = c - MINV;
`ifdef CONTRAST_DESTRETCH_ROUND_EN
      q = (c * (mx - mn) + VAL / 2) / VAL;
`else
      q = (c * (mx - mn)) / VAL;
`endif
      r = mn + q;
      if (r > mx) r = mx;
      return 8'(r);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [7:0] mn, input logic [7:0] mx, input logic with_valid);
      start   = 1'b1;
      min_i   = mn;
      max_i   = mx;
      valid_i = with_valid;
      data_i  = 8'd99;
      tick();
      start   = 1'b0;
      valid_i = 1'b0;
   endtask

   // Offers one pixel, returns first visible output and its cycle latency.
   task automatic send_pixel(input logic [7:0] px, output logic [7:0] got, output int lat);
      int n = 0;
      while (ready_o !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      valid_i = 1'b1;
      data_i  = px;
      tick();
      valid_i = 1'b0;
      lat = 1;
      while (valid_o !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
      got = data_o;
   endtask

   task automatic run_frame(input string name, input logic [7:0] mn, input logic [7:0] mx,
                            input logic [7:0] px [4]);
      logic [7:0] got, exp;
      int lat, exp_lat;
      done_cnt = 0;
      do_start(mn, mx, 1'b0);
      exp_lat = (mx <= mn) ? 1 : LAT;
      for (int i = 0; i < 4; i++) begin
         send_pixel(px[i], got, lat);
         exp = ref_out(px[i], mn, mx);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s data px=%0d min=%0d max=%0d got=%0d exp=%0d",
                     name, px[i], mn, mx, got, exp);
         end
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat);
         end
         tick();
      end
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL %s done_o got=%b exp=1", name, done_o);
      end
      tick();
      checks++;
      if (busy_o !== 1'b0 || done_cnt !== 1) begin
         errors++;
         $display("FAIL %s end busy=%b done_pulses=%0d exp busy=0 pulses=1",
                  name, busy_o, done_cnt);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({ready_o, valid_o, busy_o, done_o, data_o} !== 12'h0) begin
         errors++;
         $display("FAIL reset outputs got=%h exp=0", {ready_o, valid_o, busy_o, done_o, data_o});
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_main();
      logic [7:0] px [4];
      logic [7:0] exp [4];
      logic [7:0] got;
      int lat;
      px = '{8'd0, 8'd255, 8'd128, 8'd127};
`ifdef CONTRAST_DESTRETCH_ROUND_EN
      exp = '{8'd50, 8'd150, 8'd100, 8'd100};
`else
      exp = '{8'd50, 8'd150, 8'd100, 8'd99};
`endif
      done_cnt = 0;
      do_start(8'd50, 8'd150, 1'b1);  // pixel offered with start must be dropped
      repeat (3) tick();
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL main armed ready=%b valid=%b busy=%b exp 1 0 1", ready_o, valid_o, busy_o);
      end
      for (int i = 0; i < 4; i++) begin
         send_pixel(px[i], got, lat);
         checks++;
         if (got !== exp[i]) begin
            errors++;
            $display("FAIL main data px=%0d got=%0d exp=%0d", px[i], got, exp[i]);
         end
         checks++;
         if (lat !== LAT) begin
            errors++;
            $display("FAIL main latency got=%0d exp=%0d", lat, LAT);
         end
         tick();
      end
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL main done cycle done=%b busy=%b exp 1 1", done_o, busy_o);
      end
      tick();
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0 || done_cnt !== 1) begin
         errors++;
         $display("FAIL main after done done=%b busy=%b pulses=%0d exp 0 0 1",
                  done_o, busy_o, done_cnt);
      end
   endtask

   task automatic test_random();
      logic [7:0] px [4];
      logic [7:0] mn, mx;
      for (int f = 0; f < 6; f++) begin
         mn = 8'($urandom_range(0, 255));
         mx = 8'($urandom_range(0, 255));
         if (f == 5) mx = mn;
         for (int i = 0; i < 4; i++) px[i] = 8'($urandom_range(0, 255));
         run_frame("random", mn, mx, px);
      end
   endtask

   task automatic test_flat();
      logic [7:0] px [4];
      for (int i = 0; i < 4; i++) px[i] = 8'($urandom_range(0, 255));
      run_frame("flat", 8'd77, 8'd77, px);
   endtask

   task automatic test_backpressure();
      logic [7:0] got, exp, px;
      int lat;
      done_cnt = 0;
      do_start(8'd50, 8'd150, 1'b0);
      ready_i = 1'b0;
      send_pixel(8'd200, got, lat);
      exp = ref_out(200, 50, 150);
      valid_i = 1'b1;  // a second pixel must not be taken while stalled
      data_i  = 8'd10;
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL bp first data got=%0d exp=%0d", got, exp);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (valid_o !== 1'b1 || data_o !== exp || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp stall cyc=%0d valid=%b data=%0d ready=%b exp 1 %0d 0",
                     i, valid_o, data_o, ready_o, exp);
         end
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         px = 8'($urandom_range(0, 255));
         send_pixel(px, got, lat);
         exp = ref_out(px, 50, 150);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL bp data px=%0d got=%0d exp=%0d", px, got, exp);
         end
         tick();
      end
      checks++;
      if (done_o !== 1'b1) begin
         errors++;
         $display("FAIL bp pixel count done=%b exp=1 after 4 pixels", done_o);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [7:0] got, exp, px;
      int lat;
      do_start(8'd50, 8'd150, 1'b0);
      send_pixel(8'd30, got, lat);
      tick();
      valid_i = 1'b1;
      data_i  = 8'd60;
      tick();
      valid_i = 1'b0;
      repeat (12) tick();  // inside the divide phase
      checks++;
      if (busy_o !== 1'b1 || valid_o !== 1'b0) begin
         errors++;
         $display("FAIL rstmid pre busy=%b valid=%b exp 1 0", busy_o, valid_o);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ready_o, valid_o, busy_o, done_o, data_o} !== 12'h0) begin
         errors++;
         $display("FAIL rstmid outputs got=%h exp=0", {ready_o, valid_o, busy_o, done_o, data_o});
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      do_start(8'd0, 8'd255, 1'b0);
      for (int i = 0; i < 4; i++) begin
         px = (i == 0) ? 8'd200 : 8'($urandom_range(0, 255));
         send_pixel(px, got, lat);
         exp = ref_out(px, 0, 255);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL rstmid identity px=%0d got=%0d exp=%0d", px, got, exp);
         end
         tick();
      end
      tick();
   endtask

   task automatic test_start_ignored();
      logic [7:0] got, exp;
      logic [7:0] px [4];
      int lat;
      px = '{8'd0, 8'd255, 8'd128, 8'd127};
      done_cnt = 0;
      do_start(8'd50, 8'd150, 1'b0);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) begin
            do_start(8'd10, 8'd20, 1'b0);
            checks++;
            if (ready_o !== 1'b1 || busy_o !== 1'b1) begin
               errors++;
               $display("FAIL startign state ready=%b busy=%b exp 1 1", ready_o, busy_o);
            end
         end
         send_pixel(px[i], got, lat);
         exp = ref_out(px[i], 50, 150);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL startign data px=%0d got=%0d exp=%0d", px[i], got, exp);
         end
         tick();
      end
      tick();
      checks++;
      if (done_cnt !== 1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL startign end pulses=%0d busy=%b exp 1 0", done_cnt, busy_o);
      end
   endtask

   initial begin
      test_reset();
      test_main();
      test_random();
      test_flat();
      test_backpressure();
      test_reset_mid();
      test_start_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/contrast_destretch.md
Name: contrast_destretch

Overview:
Inverse of the contrast-stretching block. It takes a stream of stretched pixels spanning [MIN, MAX] and maps each one back to the original range [min, max]. The original min/max are latched at frame start. One pixel is in flight at a time, using a sequential shift-add multiply followed by a restoring divide. It sits after the stretch pipeline, or after storage, to reconstruct original-range images for comparison and verification.

Parameters:
- DATA_WIDTH, 8, pixel width W.
- RAM_DEPTH, 76800, pixels per frame.
- ADDR_WIDTH, $clog2(RAM_DEPTH), pixel counter width.
- MAX, 255, upper bound of the stretched range.
- MIN, 0, lower bound of the stretched range.
- VALUE, MAX-MIN, stretched span; must be nonzero.

Ports:
- clk_i_destretch  in  1  clock; one clock domain.
- rstn_i_destretch  in  1  reset, asynchronous, active-low.
- start_i_destretch  in  1  frame start pulse; latches min/max; honoured only in IDLE.
- min_i_destretch  in  W  original frame minimum.
- max_i_destretch  in  W  original frame maximum.
- valid_i_destretch  in  1  input pixel valid.
- data_i_destretch  in  W  stretched input pixel.
- ready_o_destretch  out  1  block can accept a pixel.
- valid_o_destretch  out  1  output pixel valid; held until accepted.
- data_o_destretch  out  W  restored pixel.
- ready_i_destretch  in  1  downstream accepts output.
- busy_o_destretch  out  1  high whenever the FSM is not IDLE.
- done_o_destretch  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset values: all outputs 0. FSM in IDLE. Pixel counter 0. Latched min/max 0. Reset mid-frame aborts immediately; a new start_i is required.
- FSM states: IDLE, ARMED, MULT, DIV, OUT, DONE.
- IDLE:
  - start_i=1 latches min_r and max_r, and latches flat = (max_i <= min_i).
  - Counter is cleared; FSM goes to ARMED.
- ARMED:
  - ready_o=1.
  - Handshake is valid_i & ready_o; on handshake, data_i is captured, clamped to [MIN, MAX], and d = clamped - MIN (W bits).
  - Next state is MULT, or OUT directly if flat.
- MULT: W cycles of unsigned shift-add, computing prod = d * (max_r - min_r), 2W bits.
- DIV: 2W cycles of restoring division, q = prod / VALUE (floor), W-bit result.
- Latency:
  - Handshake in cycle 0; valid_o rises in cycle 3W+1 (25 for W=8).
  - Flat frames: valid_o rises in cycle 1 with data_o = min_r.
- OUT:
  - data_o = min_r + q, saturated to max_r (q ≤ max_r - min_r by construction, so saturation is a safety net only).
  - valid_o is held, data stable, until ready_i=1. Both ready_i and valid_i are ignored outside their respective states.
  - On output handshake:
    - counter == RAM_DEPTH-1 → DONE.
    - otherwise counter++ and → ARMED.
- DONE: done_o=1 for exactly one cycle, counter cleared, FSM → IDLE.
- ready_o is 0 in every state except ARMED, so at most one pixel is in flight and there is no input buffering.
- start_i outside IDLE is ignored. min_i/max_i are only sampled on an accepted start.
- Simultaneous start_i and valid_i in IDLE: start is taken; the pixel is not accepted, because ready_o=0 that cycle.

Optional Feature:
- Macro: CONTRAST_DESTRETCH_ROUND_EN.
- Defined: dividend = prod + VALUE/2, widened to 2W+1 bits, giving round-to-nearest. The divider runs 2W+1 cycles, so latency becomes 3W+2.
- Undefined: floor division and the latency stated above.

Decomposition:
- Shared package (contrast_pkg): DATA_WIDTH, MIN, MAX and VALUE defaults; FSM state localparams (4-bit encoding, matching the stretch block); the flat-frame constant.
- One sub-module is natural: seq_restoring_div.
  - Ports: en, dividend (2W or 2W+1 bits), divisor (W bits), quotient, done.
  - Fixed cycle count, so the overall latency stays deterministic.
- The multiply stays inline.

Test Plan:
- Bench uses RAM_DEPTH=4, min=50, max=150, ready_i tied 1. Inputs 0, 255, 128, 127 → outputs 50, 150, 100, 99. done_o pulses once, one cycle after the 4th output handshake; busy_o then falls.
- Same frame with CONTRAST_DESTRETCH_ROUND_EN defined: input 127 → 100 and input 128 → 100. Latency measured as 26 cycles.
- Backpressure: ready_i=0 for 10 cycles while valid_o=1 → data_o stable, ready_o=0, no second pixel accepted, counter unchanged.
- Flat frame (min=max=77): every input → 77 with 1-cycle latency; no MULT/DIV states visited.
- Reset asserted during DIV of pixel 2 → all outputs 0 immediately. A following start_i with min=0, max=255 makes the block behave as identity: input 200 → 200.
- start_i pulsed during ARMED with different min/max → ignored; outputs still use the original latched range.
